add_shift_datapath: RTL and testbench
=====================================

// Module: add_shift_datapath
// PURPOSE
//  Register/adder datapath of the sequential shift-and-add multiplier.
//  Driven by the add-shift sequencer's add/shift/reset/ready outputs.
//  Returns Q0 (LSB of the multiplier register) to the sequencer.
//  Captures the 2N-bit product when the sequencer signals ready.
// PARAMETERS
//  N  4  operand width in bits; product is 2N bits
// PORTS
//  clock         in   1   single system clock, rising edge
//  reset         in   1   asynchronous, active-high system reset
//  init          in   1   sequencer "reset" output: load operands, clear accumulator
//  add           in   1   sequencer add strobe: {C,A} <= A + M
//  shift         in   1   sequencer shift strobe: {C,A,Q} shifted right by 1
//  ready         in   1   sequencer ready level
//  multiplicand  in   N   operand M, sampled on init
//  multiplier    in   N   operand Q, sampled on init
//  Q0            out  1   Q[0], combinational from the Q register
//  product       out  2N  captured {A,Q}
//  product_valid out  1   high from capture until next init
//  done          out  1   one-cycle pulse on capture
//  error         out  1   sticky protocol-violation flag
// BEHAVIOUR
//  Registers: C(1), A(N), Q(N), M(N), product(2N), product_valid, error, ready_d.
//  Reset (async, any time, including mid-operation): every register and output is 0.
//    Operation is abandoned; no capture follows.
//  Priority each clock edge: init > (add & shift) > add > shift > hold.
//  init: M<=multiplicand, Q<=multiplier, A<=0, C<=0, product_valid<=0, error<=0.
//    add/shift are ignored in the same cycle.
//  add & shift both high (no init): A, Q and C hold; error<=1.
//  add only: {C,A} <= {1'b0,A} + {1'b0,M}, computed at N+1 bits.
//    Q and M hold. Carry out of bit N-1 goes to C.
//  shift only: A <= {C, A[N-1:1]}, Q <= {A[0], Q[N-1:1]}, C <= 0. M holds.
//  Q0 = Q[0], updated one cycle after the shift edge.
//    The sequencer samples it during its ADDING state.
//  Multiplication sequence: for N iterations, add if Q0, then shift.
//    After the final shift, {A,Q} = M*Q exactly, with no overflow.
//  Capture: ready_d <= ready every cycle.
//    When ready & ~ready_d & ~init: product <= {A,Q}, product_valid <= 1, done <= 1.
//    done is cleared on the next edge.
//    If ready is held high, only one capture occurs.
//  init takes priority over capture: if init and the ready rising edge coincide,
//    there is no capture, product_valid stays 0 and done stays 0.
//  product keeps its last value until the next capture; only reset clears it.
//  error stays 1 until init or reset. It does not block capture;
//    the product is then unreliable and the consumer must check error.
//  add or shift after capture (no init) still updates A/Q. product is unaffected.
//  M is never modified except by init; operands may change freely outside init.
//  Latency: capture is 1 cycle after ready rises; Q0 is 1 cycle after shift or init.
// TESTING
//  N=4: init M=13,Q=11; drive the 4x(add-if-Q0, shift) sequence, then ready
//    -> product=8'h8F, done pulses once, product_valid=1.
//  N=4: M=15,Q=15 -> after adds C=1 is observed; final product=8'hE1 (225).
//  M=0,Q=9, or M=9,Q=0 -> product=8'h00; with Q=0, add is never asserted
//    by the sequencer model.
//  Assert add and shift together mid-run -> A/Q/C unchanged, error=1.
//    Error stays 1 through ready; next init -> error=0.
//  Assert reset after 2 shifts -> all outputs 0 asynchronously.
//    Fresh init M=7,Q=6 -> product=8'h2A.
//  Hold ready high for 5 cycles -> exactly one done pulse.
//    init on the same edge as ready rising -> no capture, product_valid=0.

Source files
------------

// File: rtl/add_shift_datapath.sv
// Register/adder datapath of the shift-and-add multiplier: C/A/Q/M registers,
// product capture on the rising edge of the sequencer's ready level.
module add_shift_datapath #(
   parameter int N = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             init,
   input  logic             add,
   input  logic             shift,
   input  logic             ready,
   input  logic [N-1:0]     multiplicand,
   input  logic [N-1:0]     multiplier,
   output logic             Q0,
   output logic [2*N-1:0]   product,
   output logic             product_valid,
   output logic             done,
   output logic             error
);

   logic         c;
   logic [N-1:0] a;
   logic [N-1:0] q;
   logic [N-1:0] m;
   logic         ready_d;
   logic [N:0]   sum;
   logic         capture;

   assign sum     = {1'b0, a} + {1'b0, m};
   assign capture = ready & ~ready_d & ~init;
   assign Q0      = q[0];

   // Arithmetic registers: init > conflicting strobes > add > shift > hold.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         c     <= 1'b0;
         a     <= '0;
         q     <= '0;
         m     <= '0;
         error <= 1'b0;
      end else if (init) begin
         m     <= multiplicand;
         q     <= multiplier;
         a     <= '0;
         c     <= 1'b0;
         error <= 1'b0;
      end else if (add && shift) begin
         error <= 1'b1;
      end else if (add) begin
         {c, a} <= sum;
      end else if (shift) begin
         a <= {c, a[N-1:1]};
         q <= {a[0], q[N-1:1]};
         c <= 1'b0;
      end
   end

   // Capture samples {A,Q} as they stand before this edge's add/shift.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ready_d       <= 1'b0;
         product       <= '0;
         product_valid <= 1'b0;
         done          <= 1'b0;
      end else begin
         ready_d <= ready;
         done    <= 1'b0;
         if (init) begin
            product_valid <= 1'b0;
         end else if (capture) begin
            product       <= {a, q};
            product_valid <= 1'b1;
            done          <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_add_shift_datapath.sv
// Scoreboard bench for add_shift_datapath: sequencer model drives the strobes,
// expected products (M*Q) are queued and checked whenever done pulses.
module tb_add_shift_datapath;

   localparam int N = 4;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           init = 1'b0;
   logic           add = 1'b0;
   logic           shift = 1'b0;
   logic           ready = 1'b0;
   logic [N-1:0]   multiplicand = '0;
   logic [N-1:0]   multiplier = '0;
   logic           Q0;
   logic [2*N-1:0] product;
   logic           product_valid;
   logic           done;
   logic           error;

   typedef struct {
      logic [2*N-1:0] prod;
      logic           err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   add_shift_datapath #(.N(N)) dut (
      .clock(clock), .reset(reset), .init(init), .add(add), .shift(shift),
      .ready(ready), .multiplicand(multiplicand), .multiplier(multiplier),
      .Q0(Q0), .product(product), .product_valid(product_valid),
      .done(done), .error(error)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clock) begin
      if (!reset && done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 16'd1, 16'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("product", 16'(product), 16'(e.prod));
            chk("product_valid", 16'(product_valid), 16'd1);
            chk("error_at_capture", 16'(error), 16'(e.err));
         end
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 6) begin
         cyc();
         n++;
      end
      chk(name, 16'(sb.size()), 16'd0);
   endtask

   // Load operands and perform N iterations of add-if-Q0 then shift.
   task automatic load_and_run(input logic [N-1:0] m, input logic [N-1:0] q,
                               input bit inject_err);
      multiplicand = m;
      multiplier   = q;
      init = 1'b1;
      cyc();
      init = 1'b0;
      chk("q0_after_init", 16'(Q0), 16'(q[0]));
      chk("error_cleared_by_init", 16'(error), 16'd0);
      chk("valid_cleared_by_init", 16'(product_valid), 16'd0);
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
      for (int i = 0; i < N; i++) begin
         if (inject_err && i == 1) begin
            add = 1'b1; shift = 1'b1;
            cyc();
            add = 1'b0; shift = 1'b0;
            chk("error_set", 16'(error), 16'd1);
         end
         if (Q0) begin
            add = 1'b1;
            cyc();
            add = 1'b0;
         end
         shift = 1'b1;
         cyc();
         shift = 1'b0;
      end
   endtask

   task automatic multiply(input logic [N-1:0] m, input logic [N-1:0] q,
                           input bit inject_err, input int ready_cycles);
      exp_t e;
      load_and_run(m, q, inject_err);
      e.prod = (2*N)'(m) * (2*N)'(q);
      e.err  = inject_err;
      sb.push_back(e);
      ready = 1'b1;
      repeat (ready_cycles) cyc();
      ready = 1'b0;
      drain("capture_seen");
      cyc();
   endtask

   logic [2*N-1:0] held;

   initial begin
      #2;
      @(negedge clock);
      chk("rst_product", 16'(product), 16'd0);
      chk("rst_valid", 16'(product_valid), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_error", 16'(error), 16'd0);
      chk("rst_q0", 16'(Q0), 16'd0);
      reset = 1'b0;
      cyc();

      // Directed operand pairs
      multiply(4'd13, 4'd11, 1'b0, 1);
      chk("prod_8f", 16'(product), 16'h8F);
      multiply(4'd15, 4'd15, 1'b0, 1);
      chk("prod_e1", 16'(product), 16'hE1);
      multiply(4'd0, 4'd9, 1'b0, 1);
      multiply(4'd9, 4'd0, 1'b0, 1);

      // Conflicting strobes mid-run: result intact, error sticky through ready
      multiply(4'd11, 4'd7, 1'b1, 1);
      chk("error_sticky", 16'(error), 16'd1);
      load_and_run(4'd3, 4'd5, 1'b0);
      chk("error_cleared", 16'(error), 16'd0);

      // Reset after two shifts abandons the operation
      multiply(4'd12, 4'd10, 1'b0, 1);
      multiplicand = 4'd5; multiplier = 4'd6;
      init = 1'b1; cyc(); init = 1'b0;
      shift = 1'b1; cyc(); cyc(); shift = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("async_product", 16'(product), 16'd0);
      chk("async_valid", 16'(product_valid), 16'd0);
      chk("async_done", 16'(done), 16'd0);
      chk("async_error", 16'(error), 16'd0);
      chk("async_q0", 16'(Q0), 16'd0);
      @(negedge clock);
      #1 reset = 1'b0;
      cyc(); cyc();
      chk("no_capture_after_reset", 16'(product_valid), 16'd0);
      multiply(4'd7, 4'd6, 1'b0, 1);
      chk("prod_2a", 16'(product), 16'h2A);

      // Ready held high: a single done pulse
      multiply(4'd14, 4'd9, 1'b0, 5);
      held = product;

      // Add/shift after capture leaves product alone
      shift = 1'b1; cyc(); shift = 1'b0;
      add = 1'b1; cyc(); add = 1'b0;
      chk("product_held", 16'(product), 16'(held));
      chk("valid_held", 16'(product_valid), 16'd1);

      // init coinciding with ready rising suppresses capture
      multiplicand = 4'd2; multiplier = 4'd3;
      init = 1'b1; ready = 1'b1;
      cyc();
      init = 1'b0;
      @(negedge clock);
      chk("coincide_done", 16'(done), 16'd0);
      chk("coincide_valid", 16'(product_valid), 16'd0);
      cyc();
      ready = 1'b0;
      cyc();
      chk("coincide_no_capture", 16'(product_valid), 16'd0);
      chk("coincide_product_kept", 16'(product), 16'(held));

      // Randomized operands, occasional strobe conflicts
      for (int k = 0; k < 30; k++) begin
         multiply(N'($urandom), N'($urandom), ($urandom_range(0, 4) == 0),
                  $urandom_range(1, 3));
      end

      cyc(); cyc();
      chk("sb_empty", 16'(sb.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
